// File: rtl/console_tick_monitor_if.sv
// Tick input and status outputs of the console tick monitor.
// The generator/status side uses master; the monitor uses slave.
interface console_tick_monitor_if;
  logic        tick;
  logic [31:0] period;
  logic        period_vld;
  logic [3:0]  fsamp_det;
  logic        locked;
  logic        err;
  logic        timeout;

  modport master (
    output tick,
    input  period, period_vld, fsamp_det, locked, err, timeout
  );

  modport slave (
    input  tick,
    output period, period_vld, fsamp_det, locked, err, timeout
  );
endinterface

// File: rtl/console_tick_monitor.sv
// Measures the spacing of rising edges of the console sample tick, decodes it into a
// fsamp code, and reports lock, lock loss and tick loss.
//
// state | meaning
// IDLE  | no reference edge yet; waiting for the first rising edge
// MEAS  | measuring periods, counting consecutive matches toward lock
// LOCK  | rate locked; every period must decode to fsamp_det
module console_tick_monitor #(
  parameter int unsigned N_1KHZ   = 75000,
  parameter int unsigned N_2KHZ   = 37500,
  parameter int unsigned N_4KHZ   = 18750,
  parameter int unsigned N_8KHZ   = 9375,
  parameter int unsigned N_16KHZ  = 4688,
  parameter int unsigned TOL      = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 150000
) (
  input  logic                   clk,
  input  logic                   rst,
  console_tick_monitor_if.slave  bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [31:0]       TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [MW-1:0]     LOCK_W    = MW'(LOCK_CNT);
  localparam logic signed [32:0] TOL_S    = 33'(TOL);

  typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;

  state_t        state_q, state_d;
  logic          tick_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [MW-1:0] match_q, match_d, match_new;
  logic [3:0]    last_q, last_d;
  logic [31:0]   period_q, period_d;
  logic          vld_q, vld_d;
  logic [3:0]    fsamp_q, fsamp_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;
  logic          tick_edge;
  logic [3:0]    code;

  // Signed 33-bit difference so periods below the nominal value never wrap.
  function automatic logic in_band(input logic [31:0] c, input logic [31:0] n);
    logic signed [32:0] diff;
    diff = $signed({1'b0, c}) - $signed({1'b0, n});
    return (diff >= -TOL_S) && (diff <= TOL_S);
  endfunction

  assign tick_edge = bus.tick & ~tick_d;

  always_comb begin
    code = 4'd0;
    if      (in_band(cnt_q, 32'(N_1KHZ)))  code = 4'd1;
    else if (in_band(cnt_q, 32'(N_2KHZ)))  code = 4'd2;
    else if (in_band(cnt_q, 32'(N_4KHZ)))  code = 4'd3;
    else if (in_band(cnt_q, 32'(N_8KHZ)))  code = 4'd4;
    else if (in_band(cnt_q, 32'(N_16KHZ))) code = 4'd5;
  end

  always_comb begin
    if (code != 4'd0 && code == last_q) match_new = match_q + MW'(1);
    else                                match_new = MW'(code != 4'd0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    last_d    = last_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    fsamp_d   = fsamp_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (tick_edge) begin
          state_d = MEAS;
          cnt_d   = 32'd1;
        end
      end
      MEAS, LOCK: begin
        if (tick_edge) begin
          cnt_d    = 32'd1;
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (state_q == MEAS) begin
            match_d = match_new;
            last_d  = code;
            if (match_new == LOCK_W) begin
              state_d  = LOCK;
              locked_d = 1'b1;
              fsamp_d  = code;
            end
          end else if (code != fsamp_q) begin
            state_d  = MEAS;
            err_d    = 1'b1;
            locked_d = 1'b0;
            fsamp_d  = 4'd0;
            match_d  = MW'(code != 4'd0);
            last_d   = code;
          end
        end else if (cnt_q == TIMEOUT_W) begin
          // cnt is cleared here, so the pulse fires once per loss of tick.
          state_d   = IDLE;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          fsamp_d   = 4'd0;
          match_d   = '0;
          cnt_d     = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_d    <= 1'b0;
      cnt_q     <= 32'd0;
      match_q   <= '0;
      last_q    <= 4'd0;
      period_q  <= 32'd0;
      vld_q     <= 1'b0;
      fsamp_q   <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_d    <= bus.tick;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      last_q    <= last_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      fsamp_q   <= fsamp_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = vld_q;
  assign bus.fsamp_det  = fsamp_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: doc/console_tick_monitor.md
Name: console_tick_monitor

Overview:
Receive-side checker for the console sample tick. It measures the spacing between rising edges of an incoming tick strobe in clk cycles and decodes that spacing back into the 4-bit fsamp code (0 = unknown, 1..5 = 1/2/4/8/16 kHz at 75 MHz). It asserts lock after a run of consistent periods and flags errors and timeouts. It sits downstream of the tick generator, in the acquisition/console path, and is used for status reporting and self-test.

Parameters:
N_1KHZ, 75000, nominal 1 kHz period in clk cycles
N_2KHZ, 37500, nominal 2 kHz period
N_4KHZ, 18750, nominal 4 kHz period
N_8KHZ, 9375, nominal 8 kHz period
N_16KHZ, 4688, nominal 16 kHz period (source alternates 4688/4687)
TOL, 16, accepted absolute deviation in cycles, inclusive
LOCK_CNT, 4, consecutive matching periods required for lock (>=2)
TIMEOUT, 150000, cycles without a rising edge before the monitor declares loss

Ports:
clk  in  1  system clock, 75 MHz
rst  in  1  synchronous, active-high reset
tick  in  1  sample tick from the generator, synchronous to clk
period  out  32  last measured edge-to-edge period in cycles
period_vld  out  1  one-cycle pulse when period updates
fsamp_det  out  4  decoded rate code while locked, else 0
locked  out  1  high while the rate is locked
err  out  1  one-cycle pulse when a locked rate breaks
timeout  out  1  one-cycle pulse on the timeout event

Behaviour:
- Reset: this is the already-decided interface. There is one clock, clk. rst is synchronous and active-high. On reset: state=IDLE, tick_d=0, cnt=0, match_cnt=0, last_code=0, period=0, and all outputs 0.
- Edge detect: tick_d is the registered tick. edge = tick & ~tick_d. A tick held high or low generates no edges.
- Counter cnt (32 bit):
  - On edge: cnt<=1.
  - Otherwise in MEAS/LOCK: cnt<=cnt+1, saturating at TIMEOUT.
  - In IDLE: cnt holds 0.
  - The value of cnt sampled at an edge is exactly the number of cycles since the previous edge.
- Classification (combinational on cnt at an edge): code = k if |cnt - N_k| <= TOL, with k in {1:1K, 2:2K, 4K:3, 8K:4, 16K:5}. Otherwise code = 0. Ranges do not overlap at the defaults. Compare with 33-bit signed or ordered arithmetic; no wrap.
- States:
  - IDLE: first edge -> MEAS. No period is reported for this edge. cnt<=1.
  - MEAS, on edge:
    - period<=cnt and period_vld=1 on the next cycle.
    - If code!=0 and code==last_code: match_cnt<=match_cnt+1. Otherwise match_cnt<=(code!=0).
    - last_code<=code.
    - When the updated match_cnt reaches LOCK_CNT: go to LOCK, locked<=1, fsamp_det<=code.
  - LOCK, on edge:
    - Update period and period_vld.
    - If code==fsamp_det, stay in LOCK.
    - Else: err pulse, locked<=0, fsamp_det<=0, go to MEAS, match_cnt<=(code!=0), last_code<=code.
  - MEAS or LOCK with cnt==TIMEOUT and no edge:
    - timeout pulse (once), state<=IDLE, locked<=0, fsamp_det<=0, match_cnt<=0, cnt<=0.
- Simultaneous events: an edge in the same cycle as cnt==TIMEOUT is treated as an edge; no timeout fires and the period is classified normally (code 0).
- Latency: period, period_vld, locked, fsamp_det, err and timeout are all registered and update one cycle after the edge or timeout cycle.
- Reset mid-operation: all state clears on the next clk edge. The first edge after reset starts a fresh measurement.
- Alternating 4688/4687 periods both map to code 5 and count as matches.

Test Plan:
1. Reset, then edges every 75000 cycles:
   - No period_vld on the first edge.
   - period=75000 on each subsequent edge.
   - locked=1, fsamp_det=1 one cycle after the 5th edge (4 matching periods).
2. Periods alternating 4688/4687 -> locked with fsamp_det=5 after 4 periods; period toggles between the two values.
3. Locked at 9375 (code 4), then one period of 18750:
   - err pulses for one cycle; locked=0, fsamp_det=0.
   - Relock to code 3 after 3 more 18750 periods (4 total).
4. Locked at 37500, then tick held high for 150000 cycles:
   - A single timeout pulse; locked=0, state IDLE.
   - The next edge reports no period.
5. Periods of 37516 (accepted) and 37517 (code 0):
   - The 37516 run locks with code 2.
   - A 37517 period while locked causes err and unlock.
6. rst asserted mid-lock for 1 cycle -> all outputs 0 next cycle; relock requires LOCK_CNT fresh periods.
